// File: rtl/registers.sv
// registers: four-entry N-bit register file with two combinational read
// ports and one write port whose address field carries a write-disable bit.
// Optional build macro REGISTERS_BYPASS_EN adds write-first forwarding, so a
// read that matches the pending write address returns the incoming data
// before the clock edge. Without the macro, reads show stored contents only.
module registers #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   r1,
  input  logic [1:0]   r2,
  input  logic [2:0]   w1,
  input  logic [N-1:0] w,
  output logic [N-1:0] v1,
  output logic [N-1:0] v2
);

  localparam int NUM_REGS = 4;

  // w1[2] set means the cycle carries no write (codes 4..7 are no-ops).
  logic       wr_en;
  logic [1:0] wr_addr;

  assign wr_en   = ~w1[2];
  assign wr_addr = w1[1:0];

  // Stored contents gathered from the per-register slices for the read muxes.
  logic [NUM_REGS-1:0][N-1:0] regs_q;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [N-1:0] data_q;
      logic [N-1:0] data_d;
      logic         hit;

      assign hit = wr_en && (wr_addr == 2'(gi));

      // Next state: take the full write word on an address hit, else hold.
      always_comb begin
        data_d = data_q;
        if (hit) begin
          data_d = w;
        end
      end

      // Storage: cleared asynchronously while rst is low, loaded on clk rise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign regs_q[gi] = data_q;
    end
  endgenerate

  // Forwarding is only meaningful out of reset; during reset the outputs must
  // track the cleared registers regardless of what sits on the write port.
  logic fwd_ok;
  assign fwd_ok = rst && wr_en;

  // Read port 1: stored value, optionally overridden by a matching write.
  always_comb begin
    v1 = regs_q[r1];
`ifdef REGISTERS_BYPASS_EN
    if (fwd_ok && (wr_addr == r1)) begin
      v1 = w;
    end
`else
    if (fwd_ok && 1'b0) begin
      v1 = w;
    end
`endif
  end

  // Read port 2: identical rule, fully independent of port 1.
  always_comb begin
    v2 = regs_q[r2];
`ifdef REGISTERS_BYPASS_EN
    if (fwd_ok && (wr_addr == r2)) begin
      v2 = w;
    end
`else
    if (fwd_ok && 1'b0) begin
      v2 = w;
    end
`endif
  end

endmodule

// File: tb/tb_registers.sv
// tb_registers: directed scenarios followed by randomized traffic, all read
// values compared against a plain array model of the four registers.
module tb_registers;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic [1:0]   r1;
  logic [1:0]   r2;
  logic [2:0]   w1;
  logic [N-1:0] w;
  logic [N-1:0] v1;
  logic [N-1:0] v2;

  int n_checks;
  int n_errors;

  logic [N-1:0] model [4];

  registers #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .r1  (r1),
    .r2  (r2),
    .w1  (w1),
    .w   (w),
    .v1  (v1),
    .v2  (v2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (got running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read value for an address, from the model and the current inputs.
  function automatic logic [N-1:0] exp_read(input logic [1:0] a);
    if (!rst) return '0;
`ifdef REGISTERS_BYPASS_EN
    if (!w1[2] && (w1[1:0] == a)) return w;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, ".v1"}, v1, exp_read(r1));
    check({tag, ".v2"}, v2, exp_read(r2));
  endtask

  // One clock edge: apply the write rule to the model, then let outputs settle.
  task automatic do_edge();
    @(posedge clk);
    if (rst && !w1[2]) model[w1[1:0]] = w;
    $display("edge t=%0t rst=%0b w1=%0d w=0x%08h r1=%0d r2=%0d", $time, rst, w1, w, r1, r2);
    #1;
  endtask

  task automatic mid_reset_pulse(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_model();
    #1;
    check({tag, ".rst_v1"}, v1, '0);
    check({tag, ".rst_v2"}, v2, '0);
    #2;
    rst = 1'b1;
  endtask

  logic [N-1:0] wvals [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    rst = 1'b0;
    r1  = 2'd0;
    r2  = 2'd1;
    w1  = 3'd0;
    w   = 32'd5;

    // Reset held: writes ignored, outputs stay zero across edges.
    for (int i = 0; i < 4; i++) begin
      r1 = 2'(i);
      r2 = 2'(3 - i);
      do_edge();
      check("reset_hold.v1", v1, '0);
      check("reset_hold.v2", v2, '0);
    end

    rst = 1'b1;
    #1;

    // Load R0..R3 on successive edges.
    wvals[0] = 32'd1;
    wvals[1] = 32'd3;
    wvals[2] = 32'd7;
    wvals[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      w1 = 3'(i);
      w  = wvals[i];
      do_edge();
    end
    w1 = 3'd4;
    w  = 32'd100;
    r1 = 2'd0;
    r2 = 2'd1;
    #1;
    check("load.r0", v1, 32'd1);
    check("load.r1", v2, 32'd3);
    r1 = 2'd2;
    r2 = 2'd3;
    #1;
    check("load.r2", v1, 32'd7);
    check("load.r3", v2, 32'hFFFF_FFFF);

    // No-op write codes leave everything unchanged.
    for (int i = 0; i < 3; i++) begin
      do_edge();
      check("noop.v1", v1, 32'd7);
      check("noop.v2", v2, 32'hFFFF_FFFF);
    end

    // Same-cycle write and read of R3.
    r1 = 2'd3;
    w1 = 3'd3;
    w  = 32'd0;
    #1;
`ifdef REGISTERS_BYPASS_EN
    check("wr_rd.before", v1, 32'd0);
`else
    check("wr_rd.before", v1, 32'hFFFF_FFFF);
`endif
    do_edge();
    w1 = 3'd4;
    #1;
    check("wr_rd.after", v1, 32'd0);

    // Both ports on the same address.
    r1 = 2'd2;
    r2 = 2'd2;
    #1;
    check("same_addr.v1", v1, 32'd7);
    check("same_addr.v2", v2, 32'd7);

    // Asynchronous reset mid-period.
    mid_reset_pulse("async");
    #1;
    check_reads("post_reset");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mid_reset_pulse("rand");
      end
      r1 = 2'($urandom_range(0, 3));
      r2 = 2'($urandom_range(0, 3));
      w1 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       w = '0;
        1:       w = '1;
        default: w = N'($urandom);
      endcase
      check_reads("rand.pre");
      do_edge();
      check_reads("rand.post");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
